// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the instruction/data memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        ACK   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam int DEF_ADDR_W       = 16;
    localparam int DEF_DATA_W       = 16;
    localparam int DEF_MEM_LAT      = 4;
    localparam int DEF_MAX_D_STREAK = 3;

    // Bits needed to hold the values 0..max_val (never less than one bit).
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/arb_lat_cnt.sv
// Small up counter with clear and a terminal flag. At MAX it either wraps
// to zero (serve-latency timer) or sticks (data-grant streak counter).
module arb_lat_cnt
    import mem_arb_pkg::*;
#(
    parameter int MAX = 3,
    parameter bit SAT = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic done
);

    localparam int W = cnt_w(MAX);

    logic [W-1:0] cnt;

    // Clear has priority over increment; at MAX saturate or wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            if (cnt == W'(MAX)) begin
                cnt <= SAT ? cnt : '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign done = (cnt == W'(MAX));

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and
// data access. One transaction at a time: grant in IDLE, hold address and
// control for MEM_LAT cycles, pulse the owner's ack, return to IDLE.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int MEM_LAT      = DEF_MEM_LAT,
    parameter int MAX_D_STREAK = DEF_MAX_D_STREAK
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hlt,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              idle
);

    state_t state;
    owner_t owner;

    logic fetch_ok;
    logic streak_full;
    logic lat_done;
    logic grant_d;
    logic grant_i;
    logic streak_clr;
    logic streak_inc;

    // Data normally wins; fetch wins a tie once data has used up its streak.
    always_comb begin
        fetch_ok   = i_req & ~hlt;
        grant_d    = (state == IDLE) & d_req & ~(fetch_ok & streak_full);
        grant_i    = (state == IDLE) & fetch_ok & ~grant_d;
        streak_clr = (state == IDLE) & (~i_req | grant_i);
        streak_inc = grant_d & fetch_ok;
    end

    arb_lat_cnt #(
        .MAX (MEM_LAT - 1),
        .SAT (1'b0)
    ) u_lat_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state != SERVE),
        .inc   (state == SERVE),
        .done  (lat_done)
    );

    arb_lat_cnt #(
        .MAX (MAX_D_STREAK),
        .SAT (1'b1)
    ) u_streak_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (streak_clr),
        .inc   (streak_inc),
        .done  (streak_full)
    );

    // Transaction FSM; memory controls, acks and read-data captures are all registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= OWN_I;
            i_ack     <= 1'b0;
            i_rdata   <= '0;
            d_ack     <= 1'b0;
            d_rdata   <= '0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            idle      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d || grant_i) begin
                        state     <= SERVE;
                        owner     <= grant_d ? OWN_D : OWN_I;
                        mem_re    <= grant_d ? ~d_we : 1'b1;
                        mem_we    <= grant_d & d_we;
                        mem_addr  <= grant_d ? d_addr : i_addr;
                        mem_wdata <= grant_d ? d_wdata : '0;
                        idle      <= 1'b0;
                    end
                end
                SERVE: begin
                    if (lat_done) begin
                        state     <= ACK;
                        mem_re    <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        if (owner == OWN_I) begin
                            i_ack   <= 1'b1;
                            i_rdata <= mem_rdata;
                        end else begin
                            d_ack <= 1'b1;
                            if (mem_re) begin
                                d_rdata <= mem_rdata;
                            end
                        end
                    end
                end
                ACK: begin
                    state <= IDLE;
                    i_ack <= 1'b0;
                    d_ack <= 1'b0;
                    idle  <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    idle  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then
// randomized requesters checked every cycle against a transaction-level model.
module tb_mem_arbiter;

    localparam int ADDR_W       = 16;
    localparam int DATA_W       = 16;
    localparam int MEM_LAT      = 4;
    localparam int MAX_D_STREAK = 3;

    logic              clk     = 1'b0;
    logic              rst_n   = 1'b0;
    logic              hlt     = 1'b0;
    logic              i_req   = 1'b0;
    logic [ADDR_W-1:0] i_addr  = '0;
    logic              d_req   = 1'b0;
    logic              d_we    = 1'b0;
    logic [ADDR_W-1:0] d_addr  = '0;
    logic [DATA_W-1:0] d_wdata = '0;
    logic [DATA_W-1:0] mem_rdata;
    logic              i_ack, d_ack, mem_re, mem_we, idle;
    logic [DATA_W-1:0] i_rdata, d_rdata, mem_wdata;
    logic [ADDR_W-1:0] mem_addr;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .MEM_LAT      (MEM_LAT),
        .MAX_D_STREAK (MAX_D_STREAK)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hlt       (hlt),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_ack     (i_ack),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .idle      (idle)
    );

    // Memory contents as a fixed function of the address; junk when not reading.
    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return {a[7:0], a[15:8]} ^ 16'hB5A5;
    endfunction

    always_comb mem_rdata = mem_re ? mem_word(mem_addr) : 16'hFFFF;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_seq(input string name, input string act, input string exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got '%s', required '%s' (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level reference: an active transaction is described by its
    // owner, fields and age in cycles since the grant (1..MEM_LAT serving,
    // MEM_LAT+1 acknowledging). Arbitration is applied only when no transaction is active.
    bit                m_busy   = 1'b0;
    bit                m_own_d  = 1'b0;
    bit                m_we     = 1'b0;
    logic [ADDR_W-1:0] m_addr   = '0;
    logic [DATA_W-1:0] m_wdata  = '0;
    logic [DATA_W-1:0] m_irdata = '0;
    logic [DATA_W-1:0] m_drdata = '0;
    int                m_age    = 0;
    int                m_streak = 0;
    bit                m_fetch_wants;
    bit                m_take_d;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_busy = 1'b0; m_age = 0; m_streak = 0;
                m_irdata = '0; m_drdata = '0;
            end else if (m_busy) begin
                if (m_age == MEM_LAT + 1) begin
                    m_busy = 1'b0;
                end else begin
                    m_age++;
                    if (m_age == MEM_LAT + 1) begin
                        if (!m_own_d) m_irdata = mem_word(m_addr);
                        else if (!m_we) m_drdata = mem_word(m_addr);
                    end
                end
            end else begin
                m_fetch_wants = i_req && !hlt;
                m_take_d = d_req && !(m_fetch_wants && m_streak == MAX_D_STREAK);
                if (m_take_d) begin
                    m_busy = 1'b1; m_age = 1; m_own_d = 1'b1;
                    m_we = d_we; m_addr = d_addr; m_wdata = d_wdata;
                    if (m_fetch_wants && m_streak < MAX_D_STREAK) m_streak++;
                end else if (m_fetch_wants) begin
                    m_busy = 1'b1; m_age = 1; m_own_d = 1'b0;
                    m_we = 1'b0; m_addr = i_addr; m_wdata = '0;
                    m_streak = 0;
                end
                if (!i_req) m_streak = 0;
            end
        end
    end

    // Cycle-by-cycle comparison of every output against the model.
    bit e_serve, e_ack;
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                e_serve = m_busy && (m_age <= MEM_LAT);
                e_ack   = m_busy && (m_age == MEM_LAT + 1);
                check("idle",    32'(idle),    32'(!m_busy));
                check("mem_re",  32'(mem_re),  32'(e_serve && !m_we));
                check("mem_we",  32'(mem_we),  32'(e_serve && m_we));
                if (e_serve) begin
                    check("mem_addr",  32'(mem_addr),  32'(m_addr));
                    check("mem_wdata", 32'(mem_wdata), 32'(m_own_d ? m_wdata : 16'h0));
                end
                check("i_ack",   32'(i_ack),   32'(e_ack && !m_own_d));
                check("d_ack",   32'(d_ack),   32'(e_ack && m_own_d));
                check("i_rdata", 32'(i_rdata), 32'(m_irdata));
                check("d_rdata", 32'(d_rdata), 32'(m_drdata));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    string seq;
    bit    drained;

    initial begin
        // Reset state
        repeat (2) tick();
        check("rst_idle",   32'(idle),      32'h1);
        check("rst_mem_re", 32'(mem_re),    32'h0);
        check("rst_i_ack",  32'(i_ack),     32'h0);
        check("rst_d_ack",  32'(d_ack),     32'h0);
        check("rst_addr",   32'(mem_addr),  32'h0);
        check("rst_rdata",  32'(i_rdata),   32'h0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        tick();

        // 1: single fetch
        i_req = 1'b1; i_addr = 16'h0010;
        for (int c = 1; c <= 4; c++) begin
            tick();
            check("t1_mem_re", 32'(mem_re), 32'h1);
            check("t1_addr",   32'(mem_addr), 32'h0010);
        end
        tick();
        check("t1_i_ack",   32'(i_ack),   32'h1);
        check("t1_i_rdata", 32'(i_rdata), 32'hA5A5);
        i_req = 1'b0;
        tick();
        check("t1_idle", 32'(idle), 32'h1);

        // 2: simultaneous fetch and data read, data first
        i_req = 1'b1; i_addr = 16'h0040;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0100;
        for (int c = 1; c <= 11; c++) begin
            tick();
            check("t2_d_ack", 32'(d_ack), 32'(c == 5));
            check("t2_i_ack", 32'(i_ack), 32'(c == 11));
            if (c >= 1 && c <= 4) check("t2_d_addr", 32'(mem_addr), 32'h0100);
            if (c >= 7 && c <= 10) check("t2_i_addr", 32'(mem_addr), 32'h0040);
            if (c == 5) begin
                check("t2_d_rdata", 32'(d_rdata), 32'hB5A4);
                d_req = 1'b0;
            end
        end
        i_req = 1'b0;
        tick();

        // 3: data write leaves d_rdata untouched
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0020; d_wdata = 16'h1234;
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c <= 4) begin
                check("t3_mem_we", 32'(mem_we),    32'h1);
                check("t3_mem_re", 32'(mem_re),    32'h0);
                check("t3_addr",   32'(mem_addr),  32'h0020);
                check("t3_wdata",  32'(mem_wdata), 32'h1234);
            end
        end
        check("t3_d_ack",   32'(d_ack),   32'h1);
        check("t3_d_rdata", 32'(d_rdata), 32'hB5A4);
        d_req = 1'b0; d_we = 1'b0;
        tick();

        // 4: starvation guard lets fetch in after three data grants
        seq = "";
        i_req = 1'b1; i_addr = 16'h0300;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h1000;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (d_ack) begin seq = {seq, "D"}; d_addr = d_addr + 16'h0010; end
            if (i_ack) begin seq = {seq, "I"}; i_addr = i_addr + 16'h0004; end
            if (seq.len() >= 8) break;
        end
        check_seq("t4_order", seq, "DDDIDDDI");
        i_req = 1'b0; d_req = 1'b0;
        tick();

        // 5: reset in the middle of a data read
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0200;
        tick(); tick();
        rst_n = 1'b0;
        #1;
        check("t5_idle",   32'(idle),      32'h1);
        check("t5_mem_re", 32'(mem_re),    32'h0);
        check("t5_addr",   32'(mem_addr),  32'h0);
        check("t5_d_ack",  32'(d_ack),     32'h0);
        check("t5_rdata",  32'(d_rdata),   32'h0);
        tick();
        rst_n = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            check("t5_reissue_ack", 32'(d_ack), 32'(c == 5));
        end
        check("t5_d_rdata", 32'(d_rdata), 32'hB5A7);
        d_req = 1'b0;
        tick();

        // 6: halt during a fetch finishes it, then blocks further fetches only
        i_req = 1'b1; i_addr = 16'h0400;
        tick(); tick();
        hlt = 1'b1;
        tick(); tick(); tick();
        check("t6_i_ack",   32'(i_ack),   32'h1);
        check("t6_i_rdata", 32'(i_rdata), 32'hB5A1);
        i_addr = 16'h0404;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("t6_no_fetch", 32'(mem_re), 32'h0);
        end
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0500;
        for (int c = 1; c <= 5; c++) begin
            tick();
            check("t6_d_ack", 32'(d_ack), 32'(c == 5));
        end
        check("t6_d_rdata", 32'(d_rdata), 32'hB5A0);
        d_req = 1'b0;
        tick();
        i_req = 1'b0; hlt = 1'b0;
        tick();

        // Randomized requesters, halt toggling and occasional resets
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            rst_n = 1'b1;
            if (($urandom % 300) == 0) rst_n = 1'b0;
            if (($urandom % 40) == 0) hlt = ~hlt;
            if (i_req) begin
                if (i_ack) begin
                    i_req  = (($urandom % 2) == 0);
                    i_addr = 16'($urandom);
                end
            end else if (($urandom % 3) == 0) begin
                i_req  = 1'b1;
                i_addr = 16'($urandom);
            end
            if (d_req) begin
                if (d_ack) begin
                    d_req   = (($urandom % 2) == 0);
                    d_we    = 1'($urandom);
                    d_addr  = 16'($urandom);
                    d_wdata = 16'($urandom);
                end
            end else if (($urandom % 3) == 0) begin
                d_req   = 1'b1;
                d_we    = 1'($urandom);
                d_addr  = 16'($urandom);
                d_wdata = 16'($urandom);
            end
        end

        // Let outstanding requests complete, bounded
        rst_n = 1'b1; hlt = 1'b0;
        drained = 1'b0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (i_ack) i_req = 1'b0;
            if (d_ack) d_req = 1'b0;
            if (!i_req && !d_req && idle) begin
                drained = 1'b1;
                break;
            end
        end
        check("drain", 32'(drained), 32'h1);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
